fdivsqrt_iter_ctrl: RTL

//  Sequencer for the radix-2 SRT divide/sqrt iteration datapath (the qsel2 digit-select stage plus

---
 rtl/fdivsqrt_iter_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fdivsqrt_iter_ctrl.sv
// Iteration sequencer for the radix-2 SRT divide/sqrt datapath (init, per-digit enable, done/ack).
// Optional feature: define FDIVSQRT_EARLY_TERM_EN to finish early on a zero partial residual.
module fdivsqrt_iter_ctrl #(
    parameter int NF_H  = 10,
    parameter int NF_S  = 23,
    parameter int NF_D  = 52,
    parameter int NF_Q  = 112,
    parameter int GUARD = 2,
    parameter int CNTW  = 7
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start_i,
    input  logic [1:0]      fmt_i,
    input  logic            special_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            wzero_i,
    input  logic            ack_i,
    output logic            ready_o,
    output logic            init_o,
    output logic            iter_en_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            early_o,
    output logic [CNTW-1:0] iter_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [CNTW-1:0] cnt_r;
    logic [CNTW-1:0] cnt_s;
    logic            early_r;
    logic            early_s;
    logic            init_s;
    logic            iter_en_s;
    logic            wzero_s;

    // Counter preload is the iteration count minus one, so 0 marks the last digit.
    function automatic logic [CNTW-1:0] last_iter(input logic [1:0] fmt);
        logic [CNTW-1:0] v;
        case (fmt)
            2'b10:   v = CNTW'(NF_H + GUARD - 1);
            2'b00:   v = CNTW'(NF_S + GUARD - 1);
            2'b01:   v = CNTW'(NF_D + GUARD - 1);
            default: v = CNTW'(NF_Q + GUARD - 1);
        endcase
        return v;
    endfunction

`ifdef FDIVSQRT_EARLY_TERM_EN
    assign wzero_s = wzero_i;
`else
    logic wzero_unused_s;
    assign wzero_unused_s = wzero_i;
    assign wzero_s        = 1'b0;
`endif

    // Next-state, counter and pulse decode; flush overrides every state.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        early_s   = early_r;
        init_s    = 1'b0;
        iter_en_s = 1'b0;
        if (flush_i) begin
            state_s = IDLE;
            cnt_s   = {CNTW{1'b0}};
            early_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        init_s  = 1'b1;
                        early_s = 1'b0;
                        if (special_i) begin
                            state_s = DONE;
                            cnt_s   = {CNTW{1'b0}};
                        end else begin
                            state_s = BUSY;
                            cnt_s   = last_iter(fmt_i);
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                BUSY: begin
                    if (!stall_i) begin
                        iter_en_s = 1'b1;
                        if (cnt_r == {CNTW{1'b0}}) begin
                            state_s = DONE;
                        end else if (wzero_s) begin
                            // remaining quotient digits are all zero
                            state_s = DONE;
                            early_s = 1'b1;
                        end else begin
                            cnt_s = cnt_r - {{(CNTW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_s = BUSY;
                    end
                end
                DONE: begin
                    if (ack_i) begin
                        state_s = IDLE;
                        cnt_s   = {CNTW{1'b0}};
                        early_s = 1'b0;
                    end else begin
                        state_s = DONE;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = {CNTW{1'b0}};
                    early_s = 1'b0;
                end
            endcase
        end
    end

    // State, iteration counter and early flag registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
            cnt_r   <= {CNTW{1'b0}};
            early_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            early_r <= early_s;
        end
    end

    assign ready_o    = (state_r == IDLE);
    assign busy_o     = (state_r == BUSY) || (state_r == DONE);
    assign done_o     = (state_r == DONE);
    assign early_o    = early_r;
    assign init_o     = init_s;
    assign iter_en_o  = iter_en_s;
    assign iter_cnt_o = cnt_r;

endmodule
